// File: rtl/mult_pkg.sv
// mult_pkg: shared defaults, clog2 helper and in-flight tag type for the multiplier scheduler
package mult_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_MUL_LAT = 1;
  localparam int MAX_TAGW    = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // owner is sized for the largest supported requester count; upper bits stay zero
  typedef struct packed {
    logic                vld;
    logic [MAX_TAGW-1:0] owner;
  } tag_t;
endpackage

// File: rtl/mult_rr_scheduler_arbiter.sv
// rr_arbiter: round-robin pointer with combinational one-hot grant and winner index
module rr_arbiter
  import mult_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int TAGW = clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [TAGW-1:0] win,
  output logic            any
);
  logic [TAGW-1:0] ptr;
  logic            found;
  int              j;
  always_comb begin
    found = 1'b0;
    win   = ptr;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      j = (j >= NREQ) ? j - NREQ : j;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = TAGW'(j);
      end
    end
    any   = found && !reset;
    grant = any ? NREQ'(1) << win : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) ptr <= '0;
    else if (any) ptr <= (win == TAGW'(NREQ - 1)) ? '0 : win + 1'b1;
endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one pipelined multiplier, returning
// each product to the requester that issued it
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NREQ    = DEF_NREQ,
  parameter  int MUL_LAT = DEF_MUL_LAT,
  localparam int TAGW    = clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dataa,
  input  logic [NREQ*WIDTH-1:0] req_datab,
  output logic [WIDTH-1:0]      mul_dataa,
  output logic [WIDTH-1:0]      mul_datab,
  input  logic [WIDTH-1:0]      mul_dataoutl,
  input  logic [WIDTH-1:0]      mul_dataouth,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_datal,
  output logic [WIDTH-1:0]      rsp_datah,
  output logic                  busy
);
  logic [TAGW-1:0] win;
  logic            any;
  tag_t            tags [MUL_LAT+1];
  tag_t            tail;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clock(clock),
    .reset(reset),
    .req  (req_valid),
    .grant(req_ready),
    .win  (win),
    .any  (any)
  );
  // tags[0] travels with mul_dataa/b; tags[MUL_LAT] lines up with the product
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mul_dataa <= '0;
      mul_datab <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tags[k] <= '0;
    end else begin
      if (any) begin
        mul_dataa <= req_dataa[int'(win)*WIDTH +: WIDTH];
        mul_datab <= req_datab[int'(win)*WIDTH +: WIDTH];
      end
      tags[0] <= '{vld: any, owner: MAX_TAGW'(win)};
      for (int k = 1; k <= MUL_LAT; k++) tags[k] <= tags[k-1];
    end
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= MUL_LAT; k++) busy = busy | tags[k].vld;
  end
  assign tail      = tags[MUL_LAT];
  assign rsp_valid = tail.vld ? NREQ'(1) << tail.owner : '0;
  assign rsp_datal = tail.vld ? mul_dataoutl : '0;
  assign rsp_datah = tail.vld ? mul_dataouth : '0;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed table-driven checks of the shared multiplier scheduler
module tb_mult_rr_scheduler;
  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_dataa;
  logic [127:0] req_datab;
  logic [31:0]  mul_dataa;
  logic [31:0]  mul_datab;
  logic [31:0]  mul_dataoutl;
  logic [31:0]  mul_dataouth;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_datal;
  logic [31:0]  rsp_datah;
  logic         busy;
  logic [63:0]  prod = '0;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;
  vec_t vecs [7];

  mult_rr_scheduler #(.WIDTH(32), .NREQ(4), .MUL_LAT(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dataa   (req_dataa),
    .req_datab   (req_datab),
    .mul_dataa   (mul_dataa),
    .mul_datab   (mul_datab),
    .mul_dataoutl(mul_dataoutl),
    .mul_dataouth(mul_dataouth),
    .rsp_valid   (rsp_valid),
    .rsp_datal   (rsp_datal),
    .rsp_datah   (rsp_datah),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // single-stage multiplier standing in for the parent's instance
  always @(posedge clock) prod <= 64'(mul_dataa) * 64'(mul_datab);
  assign mul_dataoutl = prod[31:0];
  assign mul_dataouth = prod[63:32];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
    req_dataa[r*32 +: 32] = a;
    req_datab[r*32 +: 32] = b;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g [7];
    vecs[0] = '{2, 32'd10, 32'd30, 32'd300, 32'd0};
    vecs[1] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{1, 32'h00010000, 32'h00010000, 32'h0, 32'h1};
    vecs[3] = '{3, 32'd0, 32'd12345, 32'd0, 32'd0};
    vecs[4] = '{1, 32'h80000000, 32'd2, 32'h0, 32'h1};
    vecs[5] = '{0, 32'd123456, 32'd654321, 32'hCEDABE40, 32'h12};
    vecs[6] = '{2, 32'd3, 32'd7, 32'd21, 32'd0};
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001};

    reset = 1'b1;
    req_valid = 4'b1111;
    req_dataa = '0;
    req_datab = '0;
    @(negedge clock);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_mul_dataa", 64'(mul_dataa), 64'h0);
    chk("reset_mul_datab", 64'(mul_datab), 64'h0);
    next_cycle();
    reset = 1'b0;
    req_valid = '0;
    next_cycle();

    for (int v = 0; v < 7; v++) begin
      set_op(vecs[v].r, vecs[v].a, vecs[v].b);
      req_valid = 4'(1 << vecs[v].r);
      @(negedge clock);
      chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(1 << vecs[v].r));
      next_cycle();
      req_valid = '0;
      @(negedge clock);
      chk($sformatf("vec%0d_early_rsp", v), 64'(rsp_valid), 64'h0);
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'h1);
      next_cycle();
      @(negedge clock);
      chk($sformatf("vec%0d_rsp_valid", v), 64'(rsp_valid), 64'(1 << vecs[v].r));
      chk($sformatf("vec%0d_datal", v), 64'(rsp_datal), 64'(vecs[v].lo));
      chk($sformatf("vec%0d_datah", v), 64'(rsp_datah), 64'(vecs[v].hi));
      next_cycle();
      chk($sformatf("vec%0d_idle_datal", v), 64'(rsp_datal), 64'h0);
    end

    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd100);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
      if (c >= 2) begin
        chk($sformatf("rr_rsp_c%0d", c), 64'(rsp_valid), 64'(1 << ((c - 2) % 4)));
        chk($sformatf("rr_datal_c%0d", c), 64'(rsp_datal), 64'(((c - 2) % 4 + 1) * 100));
      end
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    next_cycle();

    pulse_reset();
    req_valid = 4'b0111;
    next_cycle();
    next_cycle();
    next_cycle();
    req_valid = '0;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_rsp", 64'(rsp_valid), 64'h0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("post_rst_rsp_c%0d", c), 64'(rsp_valid), 64'h0);
      chk($sformatf("post_rst_busy_c%0d", c), 64'(busy), 64'h0);
      next_cycle();
    end
    req_valid = 4'b1111;
    @(negedge clock);
    chk("post_rst_first_grant", 64'(req_ready), 64'h1);
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();

    pulse_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = (c >= 3) ? 4'b1001 : 4'b0001;
      @(negedge clock);
      chk($sformatf("fair_ready_c%0d", c), 64'(req_ready), 64'(exp_g[c]));
      if (c >= 2) chk($sformatf("fair_rsp_c%0d", c), 64'(rsp_valid), 64'(exp_g[c-2]));
      next_cycle();
    end
    req_valid = '0;
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
